d_latch_sync: RTL and testbench

Synchronous single-clock D storage element with true and complementary outputs. It replaces the classic level-sensitive D latch with a clock-sampled equivalent for timing-clean use in the synchronous fabric. A gate input (`en`) gives latch-style transparent and hold behaviour, and a synchronous active-high reset forces a known state. It sits wherever a gated data hold with a complementary output is needed, e.g. control flags and polarity-select bits.

---
 rtl/d_latch_sync.sv | 19 +
 tb/tb_d_latch_sync.sv | 97 +++++++++
 2 files changed

// File: rtl/d_latch_sync.sv
// d_latch_sync: clocked D storage with gate enable and complementary outputs
module d_latch_sync #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);
    logic [WIDTH-1:0] q_r;
    always_ff @(posedge clk)
        q_r <= rst ? RESET_VALUE : en ? d : q_r;
    // both outputs derive from one register so they can never disagree
    assign q  = q_r;
    assign qb = ~q_r;
endmodule

// File: tb/tb_d_latch_sync.sv
// tb_d_latch_sync: scoreboard bench for 1-bit and 8-bit (reset 8'hA5) instances
module tb_d_latch_sync;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic d1 = 1'b0;
    logic [7:0] d8 = '0;
    logic q1, qb1;
    logic [7:0] q8, qb8;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       e1;
        logic [7:0] e8;
    } exp_t;
    exp_t sb[$];

    d_latch_sync #(.WIDTH(1), .RESET_VALUE(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .en(en), .d(d1), .q(q1), .qb(qb1)
    );
    d_latch_sync #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .d(d8), .q(q8), .qb(qb8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic r, input logic e, input logic [7:0] dv,
                         input logic x1, input logic [7:0] x8);
        exp_t it;
        logic nb1;
        logic [7:0] nb8;
        rst = r;
        en  = e;
        d1  = dv[0];
        d8  = dv;
        sb.push_back('{tag, x1, x8});
        @(posedge clk);
        #1;
        it  = sb.pop_front();
        nb1 = ~it.e1;
        nb8 = ~it.e8;
        chk({it.tag, ".q1"}, q1, it.e1);
        chk({it.tag, ".qb1"}, qb1, nb1);
        chk({it.tag, ".q8"}, q8, it.e8);
        chk({it.tag, ".qb8"}, qb8, nb8);
    endtask

    initial begin
        logic [6:0] seq;
        logic [7:0] seq8 [7];
        logic r, e, m1;
        logic [7:0] dv, m8;
        seq  = 7'b1000110;
        seq8 = '{8'h01, 8'hFE, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h3C};
        // reset with d=1, en=1 on two consecutive edges
        cycle("rst0", 1, 1, 8'hFF, 0, 8'hA5);
        cycle("rst1", 1, 1, 8'hFF, 0, 8'hA5);
        // transparent: q follows d one edge later
        for (int i = 0; i < 7; i++)
            cycle($sformatf("xp%0d", i), 0, 1, {seq8[i][7:1], seq[6-i]}, seq[6-i],
                  {seq8[i][7:1], seq[6-i]});
        // hold: load, then toggle d with en low
        cycle("load", 0, 1, 8'h81, 1, 8'h81);
        for (int i = 0; i < 4; i++)
            cycle($sformatf("hold%0d", i), 0, 0, (i % 2 == 0) ? 8'h00 : 8'h5B, 1, 8'h81);
        // reset wins over a simultaneous capture, then release
        cycle("midrst", 1, 1, 8'hFF, 0, 8'hA5);
        cycle("release", 0, 1, 8'hFF, 1, 8'hFF);
        // width / reset value
        cycle("w8rst", 1, 0, 8'h00, 0, 8'hA5);
        cycle("w8cap", 0, 1, 8'h3C, 0, 8'h3C);
        // random traffic against a behavioural model
        m1 = 1'b0;
        m8 = 8'h3C;
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 15) == 0);
            e  = 1'($urandom_range(0, 1));
            dv = 8'($urandom);
            m1 = r ? 1'b0 : e ? dv[0] : m1;
            m8 = r ? 8'hA5 : e ? dv : m8;
            cycle("rand", r, e, dv, m1, m8);
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
